usb_command_responder: RTL

- Fabric-side counterpart of the USB slave-FIFO bridge, running in the USB FIFO clock domain.
- Consumes 32-bit command words delivered by the bridge's command path and executes them against a small register file.
- Produces 16-bit response packets into an internal first-word-fall-through (FWFT) FIFO, which the bridge drains through its QEV_TX read/empty interface toward the host.

---
 rtl/usb_command_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/usb_command_responder.sv
// rtl/usb_command_responder.sv - executes host command words against a register file and queues 16-bit response packets
// Optional feature macro RESPONSE_CHECKSUM_EN: trailer becomes the modulo-2^16 sum of the packet instead of 16'hE0F0.
module usb_command_responder #(
   parameter int NREG      = 8,
   parameter int CMD_DEPTH = 4,
   parameter int TX_DEPTH  = 512
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        COMMAND_RX_DATA_BUS,
   input  logic               COMMAND_RX_RD_EN,
   output logic [15:0]        QEV_TX_DATA_BUS,
   input  logic               QEV_TX_RD_EN,
   output logic               QEV_TX_EMPTY,
   output logic [16*NREG-1:0] reg_out,
   output logic               busy,
   output logic [7:0]         cmd_drop_count
);
   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(CMD_DEPTH);
   localparam int TW = $clog2(TX_DEPTH);
   localparam logic [CW:0] CQ_FULL = (CW+1)'(CMD_DEPTH);
   localparam logic [TW:0] TX_FULL = (TW+1)'(TX_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_HEADER, S_INFO, S_PAYLOAD, S_TRAILER} state_t;
   state_t state;

   logic [31:0]   cq_mem [CMD_DEPTH];
   logic [CW-1:0] cq_rd, cq_wr;
   logic [CW:0]   cq_cnt;
   logic          cq_pop, cq_push;

   logic [15:0]   tx_mem [TX_DEPTH];
   logic [TW-1:0] tx_rd, tx_wr;
   logic [TW:0]   tx_cnt;
   logic          tx_pop, tx_room, emit;

   logic [31:0]   hold;
   logic [3:0]    op, rsp_op;
   logic [11:0]   arg, rsp_len, pay_cnt;
   logic [15:0]   data, pay_word, word, trailer;
   logic [RW-1:0] idx;
   logic          arg_ok, pseudo;
   logic [15:0]   regs [NREG];

   assign op     = hold[31:28];
   assign arg    = hold[27:16];
   assign data   = hold[15:0];
   assign idx    = arg[RW-1:0];
   assign arg_ok = arg < 12'(NREG);

   // A pop in the same cycle frees a slot, so a full queue can still accept.
   assign cq_pop  = (state == S_IDLE) && (cq_cnt != '0);
   assign cq_push = COMMAND_RX_RD_EN && ((cq_cnt != CQ_FULL) || cq_pop);

   assign tx_pop  = QEV_TX_RD_EN && (tx_cnt != '0);
   assign tx_room = (tx_cnt != TX_FULL) || tx_pop;
   assign emit    = ((state == S_HEADER) || (state == S_INFO) || (state == S_PAYLOAD) ||
                     (state == S_TRAILER)) && tx_room;

   assign QEV_TX_EMPTY    = (tx_cnt == '0);
   assign QEV_TX_DATA_BUS = QEV_TX_EMPTY ? 16'h0000 : tx_mem[tx_rd];
   assign busy            = (state != S_IDLE) || (cq_cnt != '0);

   always_comb begin
      reg_out = '0;
      for (int k = 0; k < NREG; k++) reg_out[16*k +: 16] = regs[k];
   end

   always_comb begin
      word = 16'h0000;
      case (state)
         S_HEADER:  word = 16'hBE11;
         S_INFO:    word = {rsp_op, rsp_len};
         S_PAYLOAD: word = pseudo ? {4'hA, pay_cnt} : pay_word;
         S_TRAILER: word = trailer;
         default:   word = 16'h0000;
      endcase
   end

`ifdef RESPONSE_CHECKSUM_EN
   logic [15:0] csum;
   always_ff @(posedge clk) begin
      if (rst) csum <= '0;
      else if (emit) begin
         if (state == S_HEADER) csum <= word;
         else if (state != S_TRAILER) csum <= csum + word;
      end
   end
   assign trailer = csum;
`else
   assign trailer = 16'hE0F0;
`endif

   always_ff @(posedge clk) begin
      if (cq_push) cq_mem[cq_wr] <= COMMAND_RX_DATA_BUS;
      if (emit) tx_mem[tx_wr] <= word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cq_rd <= '0; cq_wr <= '0; cq_cnt <= '0;
         tx_rd <= '0; tx_wr <= '0; tx_cnt <= '0;
         cmd_drop_count <= '0;
      end else begin
         if (cq_push) cq_wr <= cq_wr + CW'(1);
         if (cq_pop)  cq_rd <= cq_rd + CW'(1);
         if (cq_push && !cq_pop) cq_cnt <= cq_cnt + (CW+1)'(1);
         else if (cq_pop && !cq_push) cq_cnt <= cq_cnt - (CW+1)'(1);
         if (COMMAND_RX_RD_EN && !cq_push && (cmd_drop_count != 8'hFF))
            cmd_drop_count <= cmd_drop_count + 8'd1;
         if (emit)   tx_wr <= tx_wr + TW'(1);
         if (tx_pop) tx_rd <= tx_rd + TW'(1);
         if (emit && !tx_pop) tx_cnt <= tx_cnt + (TW+1)'(1);
         else if (tx_pop && !emit) tx_cnt <= tx_cnt - (TW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE; hold <= '0; rsp_op <= '0; rsp_len <= '0;
         pay_word <= '0; pay_cnt <= '0; pseudo <= 1'b0;
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
      end else begin
         case (state)
            S_IDLE: if (cq_pop) begin
               hold  <= cq_mem[cq_rd];
               state <= S_DECODE;
            end
            S_DECODE: begin
               // Error packet unless an opcode below overrides it.
               rsp_op <= 4'hF; rsp_len <= '0; pseudo <= 1'b0; state <= S_HEADER;
               case (op)
                  4'h1: if (arg_ok) begin regs[idx] <= data; state <= S_IDLE; end
                  4'h2: if (arg_ok) begin rsp_op <= op; rsp_len <= 12'd1; pay_word <= regs[idx]; end
                  4'h3: begin rsp_op <= op; rsp_len <= 12'd1; pay_word <= data; end
                  4'h4: begin rsp_op <= op; rsp_len <= arg; pseudo <= 1'b1; end
                  default: ;
               endcase
            end
            S_HEADER: if (emit) state <= S_INFO;
            S_INFO: if (emit) begin
               pay_cnt <= '0;
               state   <= (rsp_len == '0) ? S_TRAILER : S_PAYLOAD;
            end
            S_PAYLOAD: if (emit) begin
               if (pay_cnt == rsp_len - 12'd1) state <= S_TRAILER;
               else pay_cnt <= pay_cnt + 12'd1;
            end
            S_TRAILER: if (emit) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
